splitter_pulse_scheduler: RTL and testbench

//   Shares one splitter fan-out input between NREQ requesters. Queues pulse requests per

---
 rtl/splitter_pulse_scheduler.sv | 155 +++++++++++++++
 tb/tb_splitter_pulse_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/splitter_pulse_scheduler.sv
// Round-robin scheduler that queues per-requester pulse requests and issues them as edges on a
// toggle-encoded splitter input. Optional macro SPLIT_SCHED_HOLDOFF_EN enforces HOLDOFF idle cycles per pulse.

module splitter_pulse_lane #(
  parameter int CNTW = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic gnt_i,
  output logic pend_o,
  output logic ovf_o
);
  localparam logic [CNTW-1:0] CMAX = '1;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  // A request that coincides with its own grant is a pass-through: no count change, no overflow.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (req_i && !gnt_i) begin
      if (cnt_q == CMAX) ovf_d = 1'b1;
      else               cnt_d = cnt_q + CNTW'(1);
    end else if (gnt_i && !req_i) begin
      cnt_d = cnt_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign pend_o = |cnt_q;
  assign ovf_o  = ovf_q;
endmodule

module splitter_pulse_scheduler #(
  parameter int NREQ    = 4,
  parameter int CNTW    = 2,
  parameter int HOLDOFF = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  output logic            out_o,
  output logic [NREQ-1:0] gnt_o,
  output logic [NREQ-1:0] ovf_o,
  output logic            busy_o
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] pend, gnt_now, gnt_q;
  logic [IW-1:0]   rr_q, rr_d, win_idx, cand;
  logic            found, issue, out_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    splitter_pulse_lane #(.CNTW(CNTW)) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req_i  (req_i[g]),
      .gnt_i  (gnt_now[g]),
      .pend_o (pend[g]),
      .ovf_o  (ovf_o[g])
    );
  end

  // Search starts one past the last grantee; the last grantee itself is checked last.
  always_comb begin
    found   = 1'b0;
    win_idx = rr_q;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(rr_q) + k) % NREQ);
      if (!found && pend[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign issue = (state_q == S_IDLE) && found;

  always_comb begin
    gnt_now = '0;
    if (issue) gnt_now[win_idx] = 1'b1;
  end

`ifdef SPLIT_SCHED_HOLDOFF_EN
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

  logic [HW-1:0] hcnt_q, hcnt_d;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    rr_d    = issue ? win_idx : rr_q;
    case (state_q)
      S_IDLE: begin
        if (issue && HOLDOFF != 0) begin
          state_d = S_HOLD;
          hcnt_d  = HW'(HOLDOFF);
        end
      end
      S_HOLD: begin
        if (hcnt_q <= HW'(1)) state_d = S_IDLE;
        else                  hcnt_d  = hcnt_q - HW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) hcnt_q <= '0;
    else       hcnt_q <= hcnt_d;
  end
`else
  // Without hold-off every edge may issue, so the FSM never leaves IDLE.
  logic unused_holdoff;
  assign unused_holdoff = (HOLDOFF != 0);

  always_comb begin
    state_d = S_IDLE;
    rr_d    = issue ? win_idx : rr_q;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rr_q    <= IW'(NREQ - 1);
      out_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      out_q   <= out_q ^ issue;
      gnt_q   <= gnt_now;
    end
  end

  assign out_o  = out_q;
  assign gnt_o  = gnt_q;
  assign busy_o = (state_q != S_IDLE) | (|pend);
endmodule

// File: tb/tb_splitter_pulse_scheduler.sv
// Directed bench for splitter_pulse_scheduler: per-edge vector tables for pulse trains plus
// hand-written overflow, drain and asynchronous reset sequences. Honors SPLIT_SCHED_HOLDOFF_EN.

module tb_splitter_pulse_scheduler;
  localparam int HOLDOFF = 3;
`ifdef SPLIT_SCHED_HOLDOFF_EN
  localparam int SP = HOLDOFF + 1;
  localparam logic [3:0] T5_OVF = 4'b0010;
  localparam int T5_GNTS = 6;
`else
  localparam int SP = 1;
  localparam logic [3:0] T5_OVF = 4'b0000;
  localparam int T5_GNTS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0;
  logic       out, busy;
  logic [3:0] gnt, ovf;

  always #5 clk = ~clk;

  splitter_pulse_scheduler #(.NREQ(4), .CNTW(2), .HOLDOFF(HOLDOFF)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .out_o  (out),
    .gnt_o  (gnt),
    .ovf_o  (ovf),
    .busy_o (busy)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       out;
    logic       busy;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Request r0 at edge 0, r1 at edge 1; grants g[j] land on edges 1+j*SP and busy clears at n*SP.
  task automatic add_train(input logic [3:0] r0, input logic [3:0] r1,
                           input logic [3:0] g0, input logic [3:0] g1,
                           input logic [3:0] g2, input logic [3:0] g3, input int n);
    logic [3:0] gl [4];
    logic [3:0] g;
    int         issued;
    gl = '{g0, g1, g2, g3};
    issued = 0;
    tbl.push_back('{req: r0, gnt: 4'b0, out: 1'b0, busy: 1'b1, ovf: 4'b0});
    for (int e = 1; e <= n * SP + 1; e++) begin
      g = 4'b0;
      if ((e - 1) % SP == 0 && (e - 1) / SP < n) begin
        g = gl[(e - 1) / SP];
        issued++;
      end
      tbl.push_back('{req: (e == 1) ? r1 : 4'b0, gnt: g, out: issued[0],
                      busy: (e < n * SP), ovf: 4'b0});
    end
  endtask

  task automatic run_tbl(input string name);
    foreach (tbl[i]) begin
      @(negedge clk);
      req = tbl[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].gnt", name, i), gnt, tbl[i].gnt);
      chk($sformatf("%s[%0d].out", name, i), out, tbl[i].out);
      chk($sformatf("%s[%0d].busy", name, i), busy, tbl[i].busy);
      chk($sformatf("%s[%0d].ovf", name, i), ovf, tbl[i].ovf);
    end
    tbl.delete();
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    req = 4'b0;
    rst = 1'b1;
    #1;
    chk({name, ".out"}, out, 0);
    chk({name, ".gnt"}, gnt, 0);
    chk({name, ".ovf"}, ovf, 0);
    chk({name, ".busy"}, busy, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr;
    int c;

    do_reset("rst0");

    // Single pulse from requester 2.
    add_train(4'b0100, 4'b0000, 4'b0100, 4'b0, 4'b0, 4'b0, 1);
    run_tbl("t2");

    // All four requesters at once: grants in index order, out ends at 0.
    do_reset("rst3");
    add_train(4'b1111, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4);
    run_tbl("t3");

    // Grant 0, then requeue 0 and 3: pointer wraps to 3 before returning to 0.
    do_reset("rst4");
    add_train(4'b0001, 4'b1001, 4'b0001, 4'b1000, 4'b0001, 4'b0, 3);
    run_tbl("t4");

    // Requester 1 held for 10 edges: saturates with hold-off, then drains.
    do_reset("rst5");
    ngr = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req = 4'b0010;
      @(posedge clk);
      #1;
      if (gnt == 4'b0010) ngr++;
      chk($sformatf("t5.gnt_onlyreq1[%0d]", i), gnt & 4'b1101, 0);
    end
    @(negedge clk);
    req = 4'b0;
    chk("t5.ovf_after_req", ovf, T5_OVF);
    for (c = 0; c < 200 && busy; c++) begin
      @(posedge clk);
      #1;
      if (gnt == 4'b0010) ngr++;
    end
    chk("t5.drain_busy", busy, 0);
    chk("t5.grant_count", ngr, T5_GNTS);
    chk("t5.ovf_sticky", ovf, T5_OVF);
    chk("t5.out_parity", out, 0);

    // All requesters held long enough to saturate every counter.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req = 4'b1111;
    end
    @(negedge clk);
    req = 4'b0;
    chk("tovf.all", ovf, 4'b1111);

    // Reset mid-drain while out is high.
    for (c = 0; c < 2 * SP + 2 && out !== 1'b1; c++) begin
      @(posedge clk);
      #1;
    end
    chk("t1.pre_out", out, 1);
    chk("t1.pre_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t1.out", out, 0);
    chk("t1.gnt", gnt, 0);
    chk("t1.ovf", ovf, 0);
    chk("t1.busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    ngr = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (gnt != 4'b0 || busy) ngr++;
    end
    chk("t1.quiet_after_rst", ngr, 0);
    chk("t1.out_after", out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
